// File: rtl/phasediff_pkg.sv
// Shared widths, phase constants and types for the phase-difference block.
package phasediff_pkg;

  localparam int PHASE_W   = 19;
  localparam int FRAC_W    = 10;
  localparam int DIFF_W    = PHASE_W + 1;
  localparam int PHASE_PI  = 184320;
  localparam int PHASE_2PI = 368640;

  typedef logic signed [PHASE_W-1:0] phase_t;
  typedef logic signed [DIFF_W-1:0]  diff_t;

  // Two guard bits so the wrap correction can never overflow before saturation.
  localparam int EXT_W = DIFF_W + 2;
  typedef logic signed [EXT_W-1:0] ext_t;

  localparam ext_t EXT_PI    = ext_t'(PHASE_PI);
  localparam ext_t EXT_2PI   = ext_t'(PHASE_2PI);
  localparam ext_t EXT_MAX   = ext_t'((1 << (PHASE_W - 1)) - 1);
  localparam ext_t EXT_MIN   = -ext_t'(1 << (PHASE_W - 1));
  localparam phase_t PH_MAX  = phase_t'((1 << (PHASE_W - 1)) - 1);
  localparam phase_t PH_MIN  = phase_t'(1 << (PHASE_W - 1));

endpackage

// File: rtl/phasediff_phase_wrap.sv
// Combinational wrap into [-180, 180) plus saturation to the phase width.
// Wrap step is enabled by PHASEDIFF_WRAP_EN; otherwise the raw difference is saturated.
module phase_wrap
  import phasediff_pkg::*;
(
  input  diff_t  i_diff,
  output phase_t o_phase
);

  ext_t w_ext;
  ext_t w_wrapped;

  assign w_ext = {{(EXT_W - DIFF_W){i_diff[DIFF_W-1]}}, i_diff};

  always_comb begin
    w_wrapped = w_ext;
`ifdef PHASEDIFF_WRAP_EN
    if (w_ext >= EXT_PI) begin
      w_wrapped = w_ext - EXT_2PI;
    end else if (w_ext < -EXT_PI) begin
      w_wrapped = w_ext + EXT_2PI;
    end
`endif
  end

  always_comb begin
    o_phase = w_wrapped[PHASE_W-1:0];
    if (w_wrapped > EXT_MAX) begin
      o_phase = PH_MAX;
    end else if (w_wrapped < EXT_MIN) begin
      o_phase = PH_MIN;
    end
  end

endmodule

// File: rtl/phasediff.sv
// Registered, wrapped phase difference in_phase1 - in_phase2 (one clock latency).
// Build option: PHASEDIFF_WRAP_EN selects wrapped vs raw saturated difference.
module phasediff
  import phasediff_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   data_rdy,
  input  phase_t in_phase1,
  input  phase_t in_phase2,
  output phase_t out
);

  diff_t  w_diff;
  phase_t w_wrapped;
  phase_t r_out;

  // Sign-extend before subtracting so the full-range difference is exact.
  assign w_diff = {in_phase1[PHASE_W-1], in_phase1} - {in_phase2[PHASE_W-1], in_phase2};

  phase_wrap u_phase_wrap (
    .i_diff  (w_diff),
    .o_phase (w_wrapped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
    end else if (data_rdy) begin
      r_out <= w_wrapped;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_phasediff.sv
// Directed self-checking bench for phasediff; expectations follow PHASEDIFF_WRAP_EN.
module tb_phasediff;
  import phasediff_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   data_rdy;
  phase_t in_phase1;
  phase_t in_phase2;
  phase_t out;

  int n_vec  = 0;
  int n_miss = 0;

  phasediff dut (
    .clk       (clk),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .in_phase1 (in_phase1),
    .in_phase2 (in_phase2),
    .out       (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: out=%0d expected=finish", out);
    $fatal(1, "timeout");
  end

`ifdef PHASEDIFF_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  task automatic check(input string tag, input int exp);
    n_vec++;
    assert (out === phase_t'(exp)) else begin
      n_miss++;
      $error("FAIL %s: out=%0d expected=%0d", tag, out, exp);
    end
  endtask

  // Strobe one sample on the next rising edge, then sample 1 time unit later.
  task automatic strobe(input int a, input int b);
    @(negedge clk);
    in_phase1 = phase_t'(a);
    in_phase2 = phase_t'(b);
    data_rdy  = 1'b1;
    @(posedge clk);
    #1;
    data_rdy  = 1'b0;
  endtask

  int s1 [8] = '{170000, -100000, 50000, -180000, 184319, -184320, 90000, -90000};
  int s3 [8] = '{-170000, 100000, 30000, -180000, 0, 0, -95000, 95000};
  int sw [8] = '{-28640, 168640, 20000, 0, 184319, -184320, -183640, 183640};
  int sr [8] = '{262143, -200000, 20000, 0, 184319, -184320, 185000, -185000};

  initial begin
    reset     = 1'b0;
    data_rdy  = 1'b1;
    in_phase1 = phase_t'(12345);
    in_phase2 = phase_t'(-54321);
    #1;
    check("reset_immediate", 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_with_strobe", 0);

    @(negedge clk);
    data_rdy = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_no_strobe", 0);

    strobe(10240, 20480);
    check("basic_10_minus_20", -10240);
    repeat (19) @(posedge clk);
    #1;
    check("hold_19_cycles", -10240);

    strobe(174080, -174080);
    check("170_minus_m170", WRAP ? -20480 : 262143);
    strobe(-174080, 174080);
    check("m170_minus_170", WRAP ? 20480 : -262144);
    strobe(92160, -92160);
    check("plus_180_boundary", WRAP ? -184320 : 184320);
    strobe(-92160, 92160);
    check("minus_180_boundary", -184320);
    strobe(-184320, 184319);
    check("just_below_m360", WRAP ? 1 : -262144);
    strobe(184319, -184320);
    check("just_below_p360", WRAP ? -1 : 262143);
    strobe(262143, -262144);
    check("oor_positive", WRAP ? 155647 : 262143);
    strobe(-262144, 262143);
    check("oor_negative", WRAP ? -155647 : -262144);

    // Back-to-back strobes: one new result per cycle.
    @(negedge clk);
    in_phase1 = phase_t'(1000);
    in_phase2 = phase_t'(2000);
    data_rdy  = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_0", -1000);
    in_phase1 = phase_t'(0);
    in_phase2 = phase_t'(0);
    @(posedge clk);
    #1;
    check("b2b_1", 0);
    in_phase1 = phase_t'(-5000);
    in_phase2 = phase_t'(-7000);
    @(posedge clk);
    #1;
    check("b2b_2", 2000);

    // Reset mid-stream with strobe active.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midstream_reset_async", 0);
    @(negedge clk);
    data_rdy = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check("midstream_after_release", 0);
    strobe(3000, 1000);
    check("first_capture_after_reset", 2000);

    // Receiver 1 vs receiver 3 stream, strobed every 20 clocks.
    for (int i = 0; i < 8; i++) begin
      strobe(s1[i], s3[i]);
      repeat (19) @(posedge clk);
      #1;
      check($sformatf("stream_%0d", i), WRAP ? sw[i] : sr[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
